// File: rtl/uart_recv.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling from a baud counter,
// registered data/strobe outputs and a frame-error strobe on a bad stop bit.
module uart_recv #(
    parameter int unsigned CLK  = 50000000,
    parameter int unsigned BAUD = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned BAUD_CLK = CLK / BAUD;
    localparam int unsigned HALF     = BAUD_CLK / 2;
    localparam int unsigned CNT_W    = (BAUD_CLK > 1) ? $clog2(BAUD_CLK) : 1;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BAUD_M1 = CNT_W'(BAUD_CLK - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             rx_meta;
    logic             rx_s;
    logic             rx_prev;
    logic [1:0]       settle;
    logic             armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= 8'h00;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            settle    <= 2'b00;
            armed     <= 1'b0;
            data_out  <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            // The synchronizer holds its reset value for two cycles; only arm edge
            // detection once it has seen the real line high, so a line that is low at
            // reset release cannot fake a start edge.
            settle  <= {settle[0], 1'b1};
            if (settle[1] && rx_s) begin
                armed <= 1'b1;
            end

            rx_done   <= 1'b0;
            frame_err <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (armed && rx_prev && !rx_s) begin
                        state    <= StStart;
                        baud_cnt <= '0;
                        rx_busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (baud_cnt == HALF_M1) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            state   <= StIdle;
                            rx_busy <= 1'b0;
                        end else begin
                            state   <= StData;
                            bit_cnt <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (baud_cnt == BAUD_M1) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= StStop;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (baud_cnt == BAUD_M1) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            data_out <= shift_reg;
                            rx_done  <= 1'b1;
                            state    <= StIdle;
                            rx_busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= StWaitIdle;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                StWaitIdle: begin
                    if (rx_s) begin
                        state   <= StIdle;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= StIdle;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: default-rate DUT runs directed scenarios, a fast-rate DUT runs
// random frames; a frame-level model predicts every pulse cycle and data_out value.
module tb_uart_recv;

    localparam int B0 = 50000000 / 115200;
    localparam int H0 = B0 / 2;
    localparam int B1 = 1000000 / 100000;
    localparam int H1 = B1 / 2;

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst0, rst1;
    logic       line0, line1;
    logic [7:0] data_out0, data_out1;
    logic       rx_done0, rx_done1;
    logic       frame_err0, frame_err1;
    logic       rx_busy0, rx_busy1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   hold [2];
    logic [7:0] model_last [2];
    int   last_done [2];
    int   errcnt [2];
    ev_t  q0 [$];
    ev_t  q1 [$];

    uart_recv u_dut0 (
        .clk       (clk),
        .rst       (rst0),
        .uart_rx   (line0),
        .data_out  (data_out0),
        .rx_done   (rx_done0),
        .frame_err (frame_err0),
        .rx_busy   (rx_busy0)
    );

    uart_recv #(
        .CLK  (1000000),
        .BAUD (100000)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst1),
        .uart_rx   (line1),
        .data_out  (data_out1),
        .rx_done   (rx_done1),
        .frame_err (frame_err1),
        .rx_busy   (rx_busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish, limit 3000000 ns");
        $fatal(1);
    end

    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", name, d, cyc, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        if (d == 0) return q0.size();
        return q1.size();
    endfunction

    function automatic ev_t qfront(input int d);
        if (d == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic qpop(input int d);
        if (d == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic qpush(input int d, input ev_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    function automatic logic busy(input int d);
        return (d == 0) ? rx_busy0 : rx_busy1;
    endfunction

    function automatic logic [7:0] dout(input int d);
        return (d == 0) ? data_out0 : data_out1;
    endfunction

    task automatic check_dut(input int d, input logic done, input logic err,
                             input logic [7:0] dval);
        ev_t e;
        bit  have;
        while (qsize(d) > 0 && qfront(d).cyc < cyc) begin
            e = qfront(d);
            checks++;
            errors++;
            $display("FAIL missed_pulse dut%0d: nothing at cycle %0d, expected %s (0x%0h)",
                     d, e.cyc, e.err ? "frame_err" : "rx_done", e.data);
            qpop(d);
        end
        have = (qsize(d) > 0) && (qfront(d).cyc == cyc);
        e.cyc = 0; e.err = 1'b0; e.data = 8'h00;
        if (have) e = qfront(d);
        if (have && !e.err) model_last[d] = e.data;
        chk("rx_done", d, int'(done), int'(have && !e.err));
        chk("frame_err", d, int'(err), int'(have && e.err));
        chk("data_out", d, int'(dval), int'(model_last[d]));
        if (have) qpop(d);
        if (done) last_done[d] = cyc;
        if (err) errcnt[d]++;
    endtask

    always @(negedge clk) begin
        if (!hold[0]) check_dut(0, rx_done0, frame_err0, data_out0);
        if (!hold[1]) check_dut(1, rx_done1, frame_err1, data_out1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int d, input logic v);
        if (d == 0) line0 = v;
        else line1 = v;
    endtask

    // Called on a negedge; drives one 8N1 frame and queues the predicted pulse.
    task automatic send_frame(input int d, input logic [7:0] b, input logic stop,
                              input int low_extra, input bit chk_busy, output int n);
        int  bc;
        int  hc;
        ev_t e;
        bc = (d == 0) ? B0 : B1;
        hc = (d == 0) ? H0 : H1;
        n = cyc;
        e.cyc = n + 3 + hc + 9 * bc;
        e.err = !stop;
        e.data = b;
        qpush(d, e);
        set_line(d, 1'b0);
        if (chk_busy) begin
            wait_cyc(2);
            chk("busy_before_t0", d, int'(busy(d)), 0);
            wait_cyc(1);
            chk("busy_after_t0", d, int'(busy(d)), 1);
            wait_cyc(bc - 3);
        end else begin
            wait_cyc(bc);
        end
        for (int k = 0; k < 8; k++) begin
            set_line(d, b[k]);
            wait_cyc(bc);
        end
        set_line(d, stop);
        wait_cyc(bc + low_extra);
        set_line(d, 1'b1);
    endtask

    task automatic do_reset(input int d);
        hold[d] = 1'b1;
        wait_cyc(1);
        model_last[d] = 8'h00;
        if (d == 0) begin rst0 = 1'b1; q0.delete(); end
        else begin rst1 = 1'b1; q1.delete(); end
        wait_cyc(1);
        chk("rst_data_out", d, int'(dout(d)), 0);
        chk("rst_busy", d, int'(busy(d)), 0);
        chk("rst_done", d, int'((d == 0) ? rx_done0 : rx_done1), 0);
        chk("rst_err", d, int'((d == 0) ? frame_err0 : frame_err1), 0);
        if (d == 0) rst0 = 1'b0;
        else rst1 = 1'b0;
        wait_cyc(1);
        hold[d] = 1'b0;
    endtask

    task automatic run_default();
        int n, n1, d1;
        logic [7:0] c6;
        wait_cyc(2 * B0);
        send_frame(0, 8'h55, 1'b1, 0, 1'b1, n);
        chk("done_latency_0x55", 0, last_done[0] - n, 4126);
        chk("data_0x55", 0, int'(data_out0), 8'h55);

        wait_cyc(B0);
        send_frame(0, 8'hA3, 1'b1, 0, 1'b0, n1);
        d1 = last_done[0];
        chk("data_0xA3", 0, int'(data_out0), 8'hA3);
        send_frame(0, 8'h0F, 1'b1, 0, 1'b0, n);
        chk("b2b_spacing", 0, last_done[0] - d1, 4340);
        chk("data_0x0F", 0, int'(data_out0), 8'h0F);

        wait_cyc(2 * B0);
        n = cyc;
        set_line(0, 1'b0);
        wait_cyc(100);
        set_line(0, 1'b1);
        wait_cyc(119);
        chk("glitch_busy_hold", 0, int'(rx_busy0), 1);
        wait_cyc(1);
        chk("glitch_busy_fall", 0, int'(rx_busy0), 0);
        wait_cyc(B0);
        send_frame(0, 8'h3C, 1'b1, 0, 1'b0, n);
        chk("data_0x3C", 0, int'(data_out0), 8'h3C);

        wait_cyc(B0);
        send_frame(0, 8'h12, 1'b1, 0, 1'b0, n);
        send_frame(0, 8'hFF, 1'b0, 20 * B0, 1'b0, n);
        chk("break_err_count", 0, errcnt[0], 1);
        chk("break_data_held", 0, int'(data_out0), 8'h12);
        wait_cyc(2 * B0);
        send_frame(0, 8'h77, 1'b1, 0, 1'b0, n);
        chk("data_0x77", 0, int'(data_out0), 8'h77);

        // Frame 0xC6 driven by hand, reset pulsed in the middle of bit 4.
        wait_cyc(B0);
        c6 = 8'hC6;
        set_line(0, 1'b0);
        wait_cyc(B0);
        for (int k = 0; k < 8; k++) begin
            set_line(0, c6[k]);
            if (k == 4) begin
                wait_cyc(B0 / 2);
                do_reset(0);
                wait_cyc(B0 - B0 / 2 - 3);
            end else begin
                wait_cyc(B0);
            end
        end
        set_line(0, 1'b1);
        wait_cyc(2 * B0);
        chk("abort_data", 0, int'(data_out0), 0);
        chk("abort_busy", 0, int'(rx_busy0), 0);
        send_frame(0, 8'h81, 1'b1, 0, 1'b0, n);
        chk("data_0x81", 0, int'(data_out0), 8'h81);

        for (int i = 0; i < 3; i++) begin
            wait_cyc($urandom_range(0, B0));
            send_frame(0, 8'($urandom), 1'b1, 0, 1'b0, n);
        end
    endtask

    task automatic run_fast();
        int n, r, len;
        bit stop;
        wait_cyc(2 * B1);
        send_frame(1, 8'h5A, 1'b1, 0, 1'b1, n);
        chk("done_latency_0x5A", 1, last_done[1] - n, 98);
        chk("data_0x5A", 1, int'(data_out1), 8'h5A);
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                len = $urandom_range(1, H1 - 1);
                set_line(1, 1'b0);
                wait_cyc(len);
                set_line(1, 1'b1);
                wait_cyc(3 * B1);
            end else begin
                stop = (r != 1);
                send_frame(1, 8'($urandom), stop, stop ? 0 : $urandom_range(0, 3 * B1),
                           1'b0, n);
                wait_cyc(stop ? $urandom_range(0, 2 * B1) : $urandom_range(B1, 3 * B1));
            end
        end
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        line0 = 1'b1;
        line1 = 1'b1;
        hold[0] = 1'b1;
        hold[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            model_last[d] = 8'h00;
            last_done[d] = -1;
            errcnt[d] = 0;
        end
        wait_cyc(3);
        for (int d = 0; d < 2; d++) begin
            chk("init_data_out", d, int'(dout(d)), 0);
            chk("init_busy", d, int'(busy(d)), 0);
        end
        chk("init_done", 0, int'(rx_done0 | rx_done1), 0);
        chk("init_err", 0, int'(frame_err0 | frame_err1), 0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        wait_cyc(1);
        hold[0] = 1'b0;
        hold[1] = 1'b0;

        fork
            run_default();
            run_fast();
        join

        wait_cyc(10);
        chk("pending_events", 0, qsize(0), 0);
        chk("pending_events", 1, qsize(1), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 SHALL have parameter CLK, default 50000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate in baud.
REQ-003 SHALL have port clk  input  1  system clock. One clock domain only; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset. Synchronous and active-high.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port data_out  output  8  last correctly received byte.
REQ-007 SHALL have port rx_done  output  1  one-cycle pulse marking a new valid data_out.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse marking a frame with a bad stop bit.
REQ-009 SHALL have port rx_busy  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-010 SHALL define BAUD_CLK = CLK/BAUD (integer division) and HALF = BAUD_CLK/2. Defaults give 434 and 217.
REQ-011 SHALL size the baud counter to hold BAUD_CLK-1 for any legal parameter set, with no truncation.
REQ-012 SHALL pass uart_rx through a 2-flop synchronizer. The synchronizer resets to 1. All decoding uses the synchronized signal rx_s.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-014 IDLE: a falling edge on rx_s (previous 1, current 0) SHALL move the FSM to START and clear the baud counter. That edge cycle is t0.
REQ-015 START: at t0+HALF, if rx_s=0 the FSM SHALL go to DATA; if rx_s=1 it SHALL treat the edge as a glitch and return to IDLE with no pulse.
REQ-016 DATA: data bit k (k=0..7) SHALL be sampled at t0+HALF+(k+1)*BAUD_CLK and shifted in LSB first. After bit 7 the FSM SHALL go to STOP.
REQ-017 STOP: the stop bit SHALL be sampled at t0+HALF+9*BAUD_CLK.
REQ-018 Good stop bit (rx_s=1): the assembled byte SHALL load into data_out and rx_done SHALL pulse, both in the cycle after the stop sample; the FSM SHALL then return to IDLE.
REQ-019 Bad stop bit (rx_s=0): frame_err SHALL pulse one cycle after the stop sample, data_out SHALL remain unchanged, and the FSM SHALL go to WAIT_IDLE.
REQ-020 WAIT_IDLE: the FSM SHALL stay until rx_s=1, then go to IDLE. A line held low (break) therefore SHALL NOT produce further frames or pulses.
REQ-021 The return to IDLE at mid-stop-bit SHALL allow a start edge arriving in the following bit period to be accepted. Back-to-back frames SHALL be received with no lost byte.
REQ-022 rx_done and frame_err SHALL never be high together and SHALL each be exactly one cycle wide.
REQ-023 data_out SHALL hold its value between rx_done pulses. Partial shift-register contents SHALL never appear on data_out.
REQ-024 Falling edges on rx_s during START, DATA or STOP SHALL be ignored for frame detection. Only the scheduled samples SHALL matter.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, baud counter=0, bit counter=0, shift register=0x00, synchronizer flops=1, previous-rx register=1.
REQ-026 While rst=1 at a clock edge: data_out=0x00, rx_done=0, frame_err=0, rx_busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no pulse.
REQ-028 After reset is released, a new frame SHALL be accepted only on a fresh 1->0 edge of rx_s. A line already low at release SHALL NOT start a frame.

Verification
REQ-029 Default parameters, frame 0x55 at 115200 baud (stop=1) -> exactly one rx_done; data_out=0x55; rx_done exactly at t0+217+9*434+1; rx_busy high from t0+1 until rx_done.
REQ-030 Frames 0xA3 then 0x0F back-to-back with zero idle gap -> two rx_done pulses 4340 cycles apart; data_out=0xA3 then 0x0F; frame_err never asserted.
REQ-031 100-cycle low glitch on idle line -> no rx_done and no frame_err; rx_busy falls at t0+218; a following 0x3C frame is received correctly.
REQ-032 Receive 0x12, then a frame 0xFF with stop bit=0 and line then held low for 20 bit times -> frame_err pulses once; data_out stays 0x12; no further pulses until the line returns high and a new frame 0x77 yields data_out=0x77.
REQ-033 rst=1 for 1 cycle during bit 4 of frame 0xC6 -> no pulse; data_out=0x00; the next frame 0x81 is received correctly.
REQ-034 Parameters CLK=1000000, BAUD=100000 (BAUD_CLK=10, HALF=5), frame 0x5A -> rx_done at t0+96 with data_out=0x5A.
